// File: rtl/tty_frame_rx.sv
`default_nettype none
// ============================================================================
// Module   : tty_frame_rx
// Purpose  : Asynchronous serial (teletype style) frame receiver. Frame is
//            one start bit, DATA_WIDTH data bits LSB-first, one even-parity
//            bit and two stop bits. Good characters are queued in a small
//            first-word-fall-through buffer; errors are reported as pulses.
// Ports    : Clock_1MHz - system clock, rising edge
//            Rst_n      - asynchronous active-low reset
//            rx_i       - asynchronous serial line, idle high
//            o_data     - head character (bit 7 zero), 0 when empty
//            o_vld      - o_data holds a character
//            i_rdy      - consumer takes o_data when o_vld is high
//            perr_o     - one-cycle parity error pulse
//            ferr_o     - one-cycle framing error pulse
//            ovf_o      - sticky overflow flag (character dropped)
//            clr_i      - synchronous clear of ovf_o
// Revision : 1.0 - initial release
// ============================================================================
module tty_frame_rx #(
    parameter int CLK_FREQ   = 1000000,
    parameter int BAUD_RATE  = 650,
    parameter int DATA_WIDTH = 7,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       Clock_1MHz,
    input  logic       Rst_n,
    input  logic       rx_i,
    output logic [7:0] o_data,
    output logic       o_vld,
    input  logic       i_rdy,
    output logic       perr_o,
    output logic       ferr_o,
    output logic       ovf_o,
    input  logic       clr_i
);

    localparam int c_BIT   = CLK_FREQ / BAUD_RATE;
    localparam int c_HALF  = c_BIT / 2;
    localparam int c_CNT_W = $clog2(c_BIT + 1);
    localparam int c_IDX_W = $clog2(DATA_WIDTH + 1);
    localparam int c_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_OCC_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_PARITY    = 3'd3,
        S_STOP1     = 3'd4,
        S_STOP2     = 3'd5,
        S_WAIT_IDLE = 3'd6
    } state_t;

    // ------------------------------------------------------------------
    // Line synchroniser. r_rx_prev is one stage later than the value used
    // for decisions so a falling edge can be seen without metastability.
    // ------------------------------------------------------------------
    logic r_sync1;
    logic r_sync2;
    logic r_rx_prev;
    logic w_rx;
    logic w_fall;

    always_ff @(posedge Clock_1MHz or negedge Rst_n) begin
        if (!Rst_n) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync1   <= rx_i;
            r_sync2   <= r_sync1;
            r_rx_prev <= r_sync2;
        end
    end

    assign w_rx   = r_sync2;
    assign w_fall = r_rx_prev & ~r_sync2;

    // ------------------------------------------------------------------
    // Frame state machine
    // ------------------------------------------------------------------
    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [c_CNT_W-1:0]      r_cnt;
    logic [c_IDX_W-1:0]      r_idx;
    logic [DATA_WIDTH-1:0]   r_shift;
    logic                    r_par;
    logic                    r_perr;
    logic                    r_ferr;
    logic                    w_tick;
    logic                    w_push;
    logic                    w_perr_set;
    logic                    w_ferr_set;

    // The counter expires at the middle of every bit once a start edge
    // has loaded it with half a bit time.
    assign w_tick = (r_cnt == '0);

    always_ff @(posedge Clock_1MHz or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        w_perr_set  = 1'b0;
        w_ferr_set  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_fall) begin
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (w_tick) begin
                    // A line that is high again at mid start bit was a glitch.
                    w_state_nxt = w_rx ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (w_tick && (r_idx == c_IDX_W'(DATA_WIDTH - 1))) begin
                    w_state_nxt = S_PARITY;
                end
            end
            S_PARITY: begin
                if (w_tick) begin
                    w_state_nxt = S_STOP1;
                end
            end
            S_STOP1: begin
                if (w_tick) begin
                    if (!w_rx) begin
                        w_ferr_set  = 1'b1;
                        w_state_nxt = S_WAIT_IDLE;
                    end else begin
                        w_state_nxt = S_STOP2;
                    end
                end
            end
            S_STOP2: begin
                if (w_tick) begin
                    // Framing takes precedence over parity when both fail.
                    if (!w_rx) begin
                        w_ferr_set  = 1'b1;
                        w_state_nxt = S_WAIT_IDLE;
                    end else if (r_par) begin
                        w_perr_set  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_push      = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            S_WAIT_IDLE: begin
                if (w_rx) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Bit timing, bit index, shift register and running parity.
    always_ff @(posedge Clock_1MHz or negedge Rst_n) begin
        if (!Rst_n) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_par   <= 1'b0;
            r_perr  <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_perr <= w_perr_set;
            r_ferr <= w_ferr_set;
            if (r_state == S_IDLE) begin
                if (w_fall) begin
                    r_cnt <= c_CNT_W'(c_HALF);
                end
            end else if (r_state == S_WAIT_IDLE) begin
                r_cnt <= '0;
            end else if (w_tick) begin
                r_cnt <= c_CNT_W'(c_BIT - 1);
            end else begin
                r_cnt <= r_cnt - 1'b1;
            end

            if (w_tick) begin
                case (r_state)
                    S_START: begin
                        r_idx <= '0;
                        r_par <= 1'b0;
                    end
                    S_DATA: begin
                        r_idx   <= r_idx + 1'b1;
                        r_shift <= {w_rx, r_shift[DATA_WIDTH-1:1]};
                        r_par   <= r_par ^ w_rx;
                    end
                    S_PARITY: begin
                        r_par <= r_par ^ w_rx;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign perr_o = r_perr;
    assign ferr_o = r_ferr;

    // ------------------------------------------------------------------
    // First-word-fall-through character buffer
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [c_OCC_W-1:0]    r_occ;
    logic                  r_ovf;
    logic                  w_full;
    logic                  w_pop;
    logic                  w_wr;
    logic                  w_ovf_set;

    assign w_full    = (r_occ == c_OCC_W'(FIFO_DEPTH));
    assign w_pop     = o_vld & i_rdy;
    // When full, the slot being written is the one popped this same cycle.
    assign w_wr      = w_push & (~w_full | w_pop);
    assign w_ovf_set = w_push & w_full & ~w_pop;

    always_ff @(posedge Clock_1MHz) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= r_shift;
        end
    end

    always_ff @(posedge Clock_1MHz or negedge Rst_n) begin
        if (!Rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= (r_wr_ptr == c_PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_wr, w_pop})
                2'b10:   r_occ <= r_occ + 1'b1;
                2'b01:   r_occ <= r_occ - 1'b1;
                default: r_occ <= r_occ;
            endcase
            // A fresh overflow wins over a clear in the same cycle.
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (clr_i) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign o_vld = (r_occ != '0);
    assign ovf_o = r_ovf;

    always_comb begin
        o_data = '0;
        if (o_vld) begin
            o_data[DATA_WIDTH-1:0] = r_mem[r_rd_ptr];
        end
    end

endmodule
`default_nettype wire
